ublock_share_loader: RTL and testbench
======================================

// Module: ublock_share_loader
// PURPOSE
//   Front-end sequencer for the 2-share uBlock encryption core. Accepts one unmasked
//   128-bit plaintext/key pair over valid/ready and splits each into two Boolean shares
//   using externally supplied fresh randomness. Drives the core's share inputs and
//   start pulse, captures the cipher shares on core done, and presents them
//   downstream over valid/ready. One encryption in flight at a time.
// PARAMETERS
//   DW       128   data/key/share width; fixed at 128 for uBlock-128/128
// PORTS
//   clk           in   1    system clock, all logic on rising edge
//   rst           in   1    synchronous reset, active-high
//   in_valid      in   1    upstream plaintext/key valid
//   in_ready      out  1    loader can accept a new pair
//   in_plain      in   128  unmasked plaintext
//   in_key        in   128  unmasked master key
//   rnd_valid     in   1    fresh random word available
//   rnd_ready     out  1    loader consumes rnd this cycle (rnd_valid & rnd_ready)
//   rnd           in   128  fresh random mask word
//   core_plain0   out  128  plaintext share 0 to core (= rnd_p)
//   core_plain1   out  128  plaintext share 1 to core (= in_plain ^ rnd_p)
//   core_key0     out  128  key share 0 to core (= rnd_k)
//   core_key1     out  128  key share 1 to core (= in_key ^ rnd_k)
//   core_start    out  1    one-cycle start pulse to core
//   core_occupied in   1    core busy flag
//   core_done     in   1    core done flag; cipher shares valid this cycle
//   core_cipher0  in   128  cipher share 0 from core
//   core_cipher1  in   128  cipher share 1 from core
//   out_valid     out  1    result held valid
//   out_ready     in   1    downstream accepts result
//   out_data0     out  128  cipher share 0 (or recombined cipher, see CONFIGURATION)
//   out_data1     out  128  cipher share 1 (or zero, see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): state=IDLE; all outputs 0 except in_ready=1; share
//     and result registers cleared. Reset mid-operation aborts; in-flight core result dropped.
//   - FSM states and transitions:
//     IDLE : in_ready=1. in_valid -> latch in_plain/in_key, go MASK_P.
//     MASK_P: rnd_ready=1. On rnd_valid: rnd_p<=rnd; plain shares written; go MASK_K.
//     MASK_K: rnd_ready=1. On rnd_valid: rnd_k<=rnd; key shares written; go START.
//     START: if ~core_occupied -> core_start=1 for exactly this cycle, go WAIT; else hold.
//     WAIT : on core_done -> capture core_cipher0/1 into result regs, go OUT.
//     OUT  : out_valid=1; on out_ready -> go IDLE (in_ready=1 next cycle).
//   - rnd_valid low in MASK_P/MASK_K stalls indefinitely; no randomness reused: each
//     accepted rnd word used for exactly one mask.
//   - Unmasked in_plain/in_key registers cleared to 0 on leaving MASK_K (no unmasked
//     secret held while the core runs).
//   - core_plain*/core_key* registered, stable from START through end of WAIT.
//   - core_done outside WAIT ignored. core_start never asserted outside START.
//   - in_valid outside IDLE ignored (in_ready=0). out_data* stable while out_valid & ~out_ready.
//   - Minimum latency in_valid accept -> out_valid: 3 cycles + core latency (rnd_valid
//     held high, core idle, out_ready high).
//   - All XOR share arithmetic bitwise, 128-bit, no carries.
// CONFIGURATION
//   UBLOCK_UNMASK_EN defined: out_data0 = core_cipher0 ^ core_cipher1 (recombined,
//     registered at capture); out_data1 = 0.
//   UBLOCK_UNMASK_EN undefined: out_data0 = core_cipher0, out_data1 = core_cipher1
//     (shares passed through, recombination done downstream).
// TESTING
//   1 reset: assert rst 2 cycles mid-WAIT -> next cycle state IDLE, in_ready=1,
//     core_start=0, out_valid=0, all data outputs 0.
//   2 masking: in_plain=0x0123..cdef, in_key=0xfedc..3210, rnd=0xAAAA..AA then 0x5555..55
//     -> core_plain0=0xAA..AA, core_plain1=in_plain^0xAA..AA, core_key0=0x55..55,
//     core_key1=in_key^0x55..55; core_start high exactly 1 cycle.
//   3 rnd stall: hold rnd_valid=0 for 10 cycles in MASK_P -> no core_start, shares
//     unchanged; release -> flow resumes, one rnd word consumed per beat.
//   4 busy core: core_occupied=1 in START for 5 cycles -> core_start=0 until it drops,
//     then single pulse.
//   5 backpressure: out_ready=0 for 8 cycles -> out_valid and out_data* stable,
//     in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
//   6 end-to-end with core model, both macro settings: known uBlock vector -> with
//     UBLOCK_UNMASK_EN out_data0 = expected cipher, out_data1=0; without,
//     out_data0^out_data1 = expected cipher; spurious core_done in IDLE ignored.

Source files
------------

// File: rtl/ublock_share_loader.sv
// ublock_share_loader
//   Front-end sequencer for the 2-share uBlock-128/128 core. It accepts one
//   unmasked plaintext/key pair and splits each value into two Boolean shares
//   using fresh random words. It starts the core, captures the cipher shares
//   when the core reports done, and presents the result downstream.
//   Only one encryption is in flight at a time.
//
//   Optional feature, selected by the macro UBLOCK_UNMASK_EN:
//     defined   : out_data0 = cipher0 ^ cipher1 (recombined at capture), out_data1 = 0
//     undefined : out_data0 = cipher0, out_data1 = cipher1 (shares passed through)
module ublock_share_loader #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_plain,
  input  logic [DW-1:0] in_key,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  input  logic [DW-1:0] rnd,
  output logic [DW-1:0] core_plain0,
  output logic [DW-1:0] core_plain1,
  output logic [DW-1:0] core_key0,
  output logic [DW-1:0] core_key1,
  output logic          core_start,
  input  logic          core_occupied,
  input  logic          core_done,
  input  logic [DW-1:0] core_cipher0,
  input  logic [DW-1:0] core_cipher1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data0,
  output logic [DW-1:0] out_data1
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MASK_P = 3'd1,
    S_MASK_K = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] plain_q, plain_d;
  logic [DW-1:0] key_q, key_d;
  logic [DW-1:0] plain0_q, plain0_d;
  logic [DW-1:0] plain1_q, plain1_d;
  logic [DW-1:0] key0_q, key0_d;
  logic [DW-1:0] key1_q, key1_d;
  logic [DW-1:0] res0_q, res0_d;
  logic [DW-1:0] res1_q, res1_d;
  logic          in_ready_q, in_ready_d;
  logic          rnd_ready_q, rnd_ready_d;
  logic          out_valid_q, out_valid_d;

  // Boolean masking: the second share is the value XOR the mask (no carries).
  function automatic logic [DW-1:0] mask_share(input logic [DW-1:0] data,
                                               input logic [DW-1:0] mask);
    return data ^ mask;
  endfunction

  // Result word 0: recombined cipher or raw share 0, depending on the build.
  function automatic logic [DW-1:0] result_word0(input logic [DW-1:0] c0,
                                                 input logic [DW-1:0] c1);
`ifdef UBLOCK_UNMASK_EN
    return c0 ^ c1;
`else
    return c0 ^ {DW{1'b0}} ^ (c1 & {DW{1'b0}});
`endif
  endfunction

  // Result word 1: zero when recombined on chip, otherwise raw share 1.
  function automatic logic [DW-1:0] result_word1(input logic [DW-1:0] c1);
`ifdef UBLOCK_UNMASK_EN
    return c1 & {DW{1'b0}};
`else
    return c1;
`endif
  endfunction

  // Next-state, datapath update and start-pulse decode.
  always_comb begin
    state_d    = state_q;
    plain_d    = plain_q;
    key_d      = key_q;
    plain0_d   = plain0_q;
    plain1_d   = plain1_q;
    key0_d     = key0_q;
    key1_d     = key1_q;
    res0_d     = res0_q;
    res1_d     = res1_q;
    core_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          plain_d = in_plain;
          key_d   = in_key;
          state_d = S_MASK_P;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MASK_P: begin
        if (rnd_valid) begin
          plain0_d = rnd;
          plain1_d = mask_share(plain_q, rnd);
          state_d  = S_MASK_K;
        end else begin
          state_d = S_MASK_P;
        end
      end
      S_MASK_K: begin
        if (rnd_valid) begin
          key0_d  = rnd;
          key1_d  = mask_share(key_q, rnd);
          // The unmasked secrets are not kept while the core runs.
          plain_d = {DW{1'b0}};
          key_d   = {DW{1'b0}};
          state_d = S_START;
        end else begin
          state_d = S_MASK_K;
        end
      end
      S_START: begin
        // The start pulse depends on the live busy flag, so it is decoded
        // from the state register rather than registered a cycle late.
        if (!core_occupied) begin
          core_start = 1'b1;
          state_d    = S_WAIT;
        end else begin
          state_d = S_START;
        end
      end
      S_WAIT: begin
        if (core_done) begin
          res0_d  = result_word0(core_cipher0, core_cipher1);
          res1_d  = result_word1(core_cipher1);
          state_d = S_OUT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    rnd_ready_d = (state_d == S_MASK_P) || (state_d == S_MASK_K);
    out_valid_d = (state_d == S_OUT);
  end

  // State, share, result and handshake-flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      plain_q     <= {DW{1'b0}};
      key_q       <= {DW{1'b0}};
      plain0_q    <= {DW{1'b0}};
      plain1_q    <= {DW{1'b0}};
      key0_q      <= {DW{1'b0}};
      key1_q      <= {DW{1'b0}};
      res0_q      <= {DW{1'b0}};
      res1_q      <= {DW{1'b0}};
      in_ready_q  <= 1'b1;
      rnd_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      plain_q     <= plain_d;
      key_q       <= key_d;
      plain0_q    <= plain0_d;
      plain1_q    <= plain1_d;
      key0_q      <= key0_d;
      key1_q      <= key1_d;
      res0_q      <= res0_d;
      res1_q      <= res1_d;
      in_ready_q  <= in_ready_d;
      rnd_ready_q <= rnd_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign rnd_ready   = rnd_ready_q;
  assign out_valid   = out_valid_q;
  assign core_plain0 = plain0_q;
  assign core_plain1 = plain1_q;
  assign core_key0   = key0_q;
  assign core_key1   = key1_q;
  assign out_data0   = res0_q;
  assign out_data1   = res1_q;

endmodule

// File: tb/tb_ublock_share_loader.sv
// Bench for ublock_share_loader. It contains a stand-in core that computes a
// simple keyed function from the recombined shares and returns the result
// re-masked. It also contains a transaction-level model that derives each
// expected output from the accepted pair and the random words consumed.
module tb_ublock_share_loader;
  localparam int DW  = 128;
  localparam int LAT = 4;
`ifdef UBLOCK_UNMASK_EN
  localparam bit UNMASK = 1'b1;
`else
  localparam bit UNMASK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, rnd_valid, rnd_ready, core_start;
  logic core_occupied, core_done, out_valid, out_ready;
  logic [DW-1:0] in_plain, in_key, rnd;
  logic [DW-1:0] core_plain0, core_plain1, core_key0, core_key1;
  logic [DW-1:0] core_cipher0, core_cipher1, out_data0, out_data1;

  ublock_share_loader #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_plain(in_plain), .in_key(in_key), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .rnd(rnd), .core_plain0(core_plain0),
    .core_plain1(core_plain1), .core_key0(core_key0), .core_key1(core_key1),
    .core_start(core_start), .core_occupied(core_occupied),
    .core_done(core_done), .core_cipher0(core_cipher0),
    .core_cipher1(core_cipher1), .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Stand-in cipher: the loader is transparent to the function the core computes.
  function automatic logic [DW-1:0] cipher_f(input logic [DW-1:0] p, input logic [DW-1:0] k);
    return p ^ {k[63:0], k[127:64]} ^ {16{8'h0F}};
  endfunction

  function automatic logic [DW-1:0] rnd_word(input int i);
    logic [31:0] w;
    if (i == 0) return {16{8'hAA}};
    if (i == 1) return {16{8'h55}};
    w = 32'h9E3779B9 * i;
    return {w, ~w, w ^ 32'h1234_5678, w + 32'd7};
  endfunction

  // Random source: a fresh word after every accepted beat.
  int rnd_idx = 0;
  assign rnd = rnd_word(rnd_idx);
  always @(posedge clk) if (rnd_valid && rnd_ready) rnd_idx <= rnd_idx + 1;

  // Stand-in core, not reset by rst so that an aborted run still finishes.
  logic          busy = 1'b0, done_q = 1'b0, force_occ, spur_done;
  int            cnt = 0;
  logic [31:0]   mseed = 32'h1;
  logic [DW-1:0] pt = '0, kt = '0, c0 = '0, c1 = '0;
  assign core_occupied = busy | force_occ;
  assign core_done     = done_q | spur_done;
  assign core_cipher0  = c0;
  assign core_cipher1  = c1;
  always @(posedge clk) begin
    done_q <= 1'b0;
    if (busy) begin
      if (cnt == 1) begin
        busy   <= 1'b0;
        done_q <= 1'b1;
        c0     <= {4{mseed}};
        c1     <= cipher_f(pt, kt) ^ {4{mseed}};
        mseed  <= mseed * 32'd1103515245 + 32'd12345;
      end
      cnt <= cnt - 1;
    end else if (core_start) begin
      busy <= 1'b1;
      cnt  <= LAT;
      pt   <= core_plain0 ^ core_plain1;
      kt   <= core_key0 ^ core_key1;
    end
  end

  // Transaction model and per-cycle compare.
  bit            m_active = 0, m_started = 0, m_result = 0;
  int            m_beats = 0;
  logic [DW-1:0] m_plain = '0, m_key = '0;
  logic [DW-1:0] e_p0 = '0, e_p1 = '0, e_k0 = '0, e_k1 = '0, e_d0 = '0, e_d1 = '0;
  bit            exp_start;
  always @(negedge clk) begin
    if (rst) begin
      m_active = 0; m_started = 0; m_result = 0; m_beats = 0;
      m_plain = '0; m_key = '0;
      e_p0 = '0; e_p1 = '0; e_k0 = '0; e_k1 = '0; e_d0 = '0; e_d1 = '0;
    end else begin
      exp_start = m_active && (m_beats == 2) && !m_started && !core_occupied;
      chk1("mon_in_ready", in_ready, !m_active);
      chk1("mon_rnd_ready", rnd_ready, m_active && (m_beats < 2));
      chk1("mon_core_start", core_start, exp_start);
      chk1("mon_out_valid", out_valid, m_result);
      chk("mon_core_plain0", core_plain0, e_p0);
      chk("mon_core_plain1", core_plain1, e_p1);
      chk("mon_core_key0", core_key0, e_k0);
      chk("mon_core_key1", core_key1, e_k1);
      chk("mon_out_data0", out_data0, e_d0);
      chk("mon_out_data1", out_data1, e_d1);
      if (!m_active && in_valid) begin
        m_active = 1; m_beats = 0; m_started = 0; m_result = 0;
        m_plain = in_plain; m_key = in_key;
      end else if (m_active && (m_beats < 2) && rnd_valid) begin
        if (m_beats == 0) begin
          e_p0 = rnd; e_p1 = m_plain ^ rnd;
        end else begin
          e_k0 = rnd; e_k1 = m_key ^ rnd;
        end
        m_beats++;
      end else if (exp_start) begin
        m_started = 1;
      end else if (m_started && !m_result && core_done) begin
        m_result = 1;
        e_d0 = UNMASK ? (core_cipher0 ^ core_cipher1) : core_cipher0;
        e_d1 = UNMASK ? '0 : core_cipher1;
        chk("mon_recombined", core_cipher0 ^ core_cipher1, cipher_f(m_plain, m_key));
      end else if (m_result && out_ready) begin
        m_active = 0; m_started = 0; m_result = 0;
      end
    end
  end

  task automatic send(input logic [DW-1:0] p, input logic [DW-1:0] k);
    bit seen = 0;
    in_valid = 1'b1; in_plain = p; in_key = k;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (in_ready) seen = 1;
    end
    chk1("send_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (core_start) seen = 1;
    end
    chk1("start_timeout", core_start, 1'b1);
  endtask

  task automatic wait_outv();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk1("outv_timeout", out_valid, 1'b1);
  endtask

  task automatic chk_result(input string name, input logic [DW-1:0] exp_c);
    if (UNMASK) begin
      chk({name, "_d0"}, out_data0, exp_c);
      chk({name, "_d1"}, out_data1, '0);
    end else begin
      chk({name, "_xor"}, out_data0 ^ out_data1, exp_c);
    end
  endtask

  localparam logic [DW-1:0] P2 = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [DW-1:0] K2 = 128'hfedcba9876543210fedcba9876543210;
  localparam logic [DW-1:0] SH = 128'hab89efcd23016745ab89efcd23016745;

  int idx0;
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_plain = '0; in_key = '0;
    rnd_valid = 1'b1; out_ready = 1'b1; force_occ = 1'b0; spur_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_rnd_ready", rnd_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_core_start", core_start, 1'b0);
    chk("rst_out_data0", out_data0, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Masking with the two fixed random words.
    send(P2, K2);
    wait_start();
    chk("t2_plain0", core_plain0, {16{8'hAA}});
    chk("t2_plain1", core_plain1, SH);
    chk("t2_key0", core_key0, {16{8'h55}});
    chk("t2_key1", core_key1, SH);
    @(negedge clk);
    chk1("t2_start_single", core_start, 1'b0);
    wait_outv();
    chk_result("t2_result", {16{8'hF0}});
    @(posedge clk); #1;

    // Randomness stall in MASK_P.
    rnd_valid = 1'b0;
    idx0 = rnd_idx;
    send(128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("t3_no_start", core_start, 1'b0);
      chk1("t3_rnd_ready", rnd_ready, 1'b1);
      chk("t3_plain0_held", core_plain0, {16{8'hAA}});
    end
    @(posedge clk); #1;
    rnd_valid = 1'b1;
    wait_start();
    chk("t3_rnd_used", 128'(rnd_idx - idx0), 128'd2);
    wait_outv();
    @(posedge clk); #1;

    // Busy core holds off the start pulse.
    force_occ = 1'b1;
    send(128'hdead_beef_0000_0001_cafe_f00d_0000_0002, 128'h0123_0123_4567_4567_89ab_89ab_cdef_cdef);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("t4_no_start", core_start, 1'b0);
    end
    @(posedge clk); #1;
    force_occ = 1'b0;
    wait_start();
    @(negedge clk);
    chk1("t4_start_single", core_start, 1'b0);
    wait_outv();
    @(posedge clk); #1;

    // Output backpressure; input pulses must be ignored.
    out_ready = 1'b0;
    send(128'h5, 128'ha);
    wait_outv();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 1); in_plain = {4{32'h7777_0000 + i}};
      @(negedge clk);
      chk1("t5_out_valid", out_valid, 1'b1);
      chk1("t5_in_ready", in_ready, 1'b0);
      chk_result("t5_hold", cipher_f(128'h5, 128'ha));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("t5_idle_in_ready", in_ready, 1'b1);
    chk1("t5_idle_out_valid", out_valid, 1'b0);
    chk1("t5_no_new_txn", rnd_ready, 1'b0);

    // Spurious done in IDLE, then an end-to-end vector.
    @(posedge clk); #1;
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    @(negedge clk);
    chk1("t6_spur_out_valid", out_valid, 1'b0);
    chk1("t6_spur_in_ready", in_ready, 1'b1);
    send('0, 128'h000102030405060708090a0b0c0d0e0f);
    wait_outv();
    chk_result("t6_result", 128'h07060504030201000f0e0d0c0b0a0908);
    @(posedge clk); #1;

    // Reset asserted while the core is running.
    send(P2, K2);
    wait_start();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("t1_in_ready", in_ready, 1'b1);
    chk1("t1_core_start", core_start, 1'b0);
    chk1("t1_out_valid", out_valid, 1'b0);
    chk("t1_plain0", core_plain0, '0);
    chk("t1_plain1", core_plain1, '0);
    chk("t1_key0", core_key0, '0);
    chk("t1_key1", core_key1, '0);
    chk("t1_out0", out_data0, '0);
    chk("t1_out1", out_data1, '0);
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk1("t1_dropped", out_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
